// File: rtl/sim_bus_slave_port_pkg.sv
// Shared bus encodings and slave FSM state codes for the simulated system bus.
package sim_bus_slave_port_pkg;

    localparam int         XSimBusDeviceWidth = 5;
    localparam logic [4:0] XSimBusNoDevice    = 5'd31;

    localparam logic XSimBusRead  = 1'b0;
    localparam logic XSimBusWrite = 1'b1;

    typedef enum logic [1:0] {
        SLV_IDLE    = 2'd0,
        SLV_WAIT    = 2'd1,
        SLV_ACK     = 2'd2,
        SLV_HOLDOFF = 2'd3
    } slv_state_e;

endpackage

// File: rtl/sim_bus_slave_mem.sv
// Byte storage for a bus slave: synchronous write, combinational read, cleared on reset.
// Out-of-range addresses read as zero, ignore writes and are flagged on o_oor.
module sim_bus_slave_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_oor
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;

    // One extra bit so DEPTH == 2**ADDR_W is representable
    assign w_in_range = ({1'b0, i_addr} < DEPTH_EXT);
    assign w_idx      = i_addr[IDX_W-1:0];
    assign o_oor      = ~w_in_range;
    assign o_rdata    = w_in_range ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_in_range) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/sim_bus_slave_port.sv
// Bus slave responder: claims transactions for DEV_ID, waits WAIT_CYCLES, then
// performs one byte access and pulses ack; holds off until the master drops sel.
module sim_bus_slave_port
    import sim_bus_slave_port_pkg::*;
#(
    parameter int DEV_ID      = 1,
    parameter int DEV_ID_W    = XSimBusDeviceWidth,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold_in,
    input  logic [DEV_ID_W-1:0] device_id_in,
    input  logic [ADDR_W-1:0]   device_addr_in,
    input  logic                rw_in,
    input  logic [DATA_W-1:0]   wdata_in,
    output logic [DATA_W-1:0]   rdata_out,
    output logic                ack_out,
    output logic                err_out,
    output logic                busy_out
);

    localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [DEV_ID_W-1:0] MY_ID     = DEV_ID_W'(DEV_ID);
    localparam logic [DEV_ID_W-1:0] NO_DEV    = DEV_ID_W'(XSimBusNoDevice);

    slv_state_e        r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_ack, w_ack_nxt;
    logic              r_err, w_err_nxt;
    logic              r_busy;
    logic              w_sel;
    logic              w_latch;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;
    logic              w_mem_oor;

    // The no-device code never selects, even if DEV_ID was set to it
    assign w_sel = hold_in && (device_id_in == MY_ID) && (device_id_in != NO_DEV);

    sim_bus_slave_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata),
        .o_oor   (w_mem_oor)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_latch     = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            SLV_IDLE: begin
                if (w_sel) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = WAIT_INIT;
                    w_state_nxt = SLV_WAIT;
                end
            end
            SLV_WAIT: begin
                if (!w_sel) begin
                    w_state_nxt = SLV_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = SLV_ACK;
                    if (w_mem_oor) begin
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                    end else if (r_rw == XSimBusWrite) begin
                        w_mem_we    = 1'b1;
                        w_rdata_nxt = '0;
                    end else if (r_rw == XSimBusRead) begin
                        w_rdata_nxt = w_mem_rdata;
                    end
                end
            end
            SLV_ACK: begin
                w_state_nxt = SLV_HOLDOFF;
            end
            SLV_HOLDOFF: begin
                if (!w_sel) begin
                    w_state_nxt = SLV_IDLE;
                end
            end
            default: begin
                w_state_nxt = SLV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            // Tracks the state register exactly, so busy rises with WAIT entry
            r_busy  <= (w_state_nxt != SLV_IDLE);
            if (w_latch) begin
                r_addr  <= device_addr_in;
                r_rw    <= rw_in;
                r_wdata <= wdata_in;
            end
        end
    end

    assign rdata_out = r_rdata;
    assign ack_out   = r_ack;
    assign err_out   = r_err;
    assign busy_out  = r_busy;

endmodule

// File: tb/tb_sim_bus_slave_port.sv
// Four slaves on one shared bus, checked every cycle against a transaction-level model.
module tb_sim_bus_slave_port;

    localparam int NDEV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold_in;
    logic [4:0] device_id_in;
    logic [7:0] device_addr_in;
    logic       rw_in;
    logic [7:0] wdata_in;

    logic [7:0] rdata_o [NDEV];
    logic       ack_o   [NDEV];
    logic       err_o   [NDEV];
    logic       busy_o  [NDEV];

    int n_asrt = 0;
    int n_fail = 0;

    logic [7:0] mem_m   [NDEV][256];
    logic [7:0] last_rd [NDEV];

    always #5 clk = ~clk;

    sim_bus_slave_port #(.DEV_ID(1), .DEPTH(256), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .hold_in(hold_in), .device_id_in(device_id_in),
        .device_addr_in(device_addr_in), .rw_in(rw_in), .wdata_in(wdata_in),
        .rdata_out(rdata_o[0]), .ack_out(ack_o[0]), .err_out(err_o[0]), .busy_out(busy_o[0]));
    sim_bus_slave_port #(.DEV_ID(4), .DEPTH(256), .WAIT_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .hold_in(hold_in), .device_id_in(device_id_in),
        .device_addr_in(device_addr_in), .rw_in(rw_in), .wdata_in(wdata_in),
        .rdata_out(rdata_o[1]), .ack_out(ack_o[1]), .err_out(err_o[1]), .busy_out(busy_o[1]));
    sim_bus_slave_port #(.DEV_ID(6), .DEPTH(16), .WAIT_CYCLES(0)) u_c (
        .clk(clk), .rst(rst), .hold_in(hold_in), .device_id_in(device_id_in),
        .device_addr_in(device_addr_in), .rw_in(rw_in), .wdata_in(wdata_in),
        .rdata_out(rdata_o[2]), .ack_out(ack_o[2]), .err_out(err_o[2]), .busy_out(busy_o[2]));
    sim_bus_slave_port #(.DEV_ID(31), .DEPTH(256), .WAIT_CYCLES(2)) u_e (
        .clk(clk), .rst(rst), .hold_in(hold_in), .device_id_in(device_id_in),
        .device_addr_in(device_addr_in), .rw_in(rw_in), .wdata_in(wdata_in),
        .rdata_out(rdata_o[3]), .ack_out(ack_o[3]), .err_out(err_o[3]), .busy_out(busy_o[3]));

    function automatic int id_of(input int d);
        case (d)
            0: return 1;
            1: return 4;
            2: return 6;
            default: return 31;
        endcase
    endfunction

    function automatic int wait_of(input int d);
        case (d)
            0: return 1;
            1: return 3;
            2: return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int depth_of(input int d);
        return (d == 2) ? 16 : 256;
    endfunction

    // A device answers only to its own id, and id 31 means "nobody"
    function automatic int dev_of(input logic [4:0] id);
        for (int d = 0; d < NDEV; d++) begin
            if (id != 5'd31 && int'(id) == id_of(d)) return d;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input int d, input int k,
                       input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dev%0d step%0d: observed %h expected %h", tag, d, k, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < NDEV; d++) begin
            last_rd[d] = 8'h00;
            for (int a = 0; a < 256; a++) mem_m[d][a] = 8'h00;
        end
    endtask

    task automatic chk_all(input int k, input int t, input bit ack_now, input bit oor, input bit busy_t);
        for (int d = 0; d < NDEV; d++) begin
            chk("ack",   d, k, {7'b0, ack_o[d]},  {7'b0, ack_now && d == t});
            chk("err",   d, k, {7'b0, err_o[d]},  {7'b0, ack_now && d == t && oor});
            chk("busy",  d, k, {7'b0, busy_o[d]}, {7'b0, busy_t && d == t});
            chk("rdata", d, k, rdata_o[d], last_rd[d]);
        end
    endtask

    // Drives one bus request for sel_cycles edges, then gap edges with hold low.
    // The access completes only if sel is still sampled high at edge E0+W+1.
    task automatic txn(input logic [4:0] id, input logic [7:0] addr, input logic rw,
                       input logic [7:0] wd, input int sel_cycles, input int gap);
        int  t;
        int  w;
        bit  comp;
        bit  oor;
        bit  ack_now;
        t    = dev_of(id);
        w    = (t >= 0) ? wait_of(t) : 0;
        comp = (t >= 0) && (sel_cycles >= w + 2);
        oor  = (t >= 0) && (int'(addr) >= depth_of(t));
        hold_in        = 1'b1;
        device_id_in   = id;
        device_addr_in = addr;
        rw_in          = rw;
        wdata_in       = wd;
        for (int k = 0; k < sel_cycles + gap; k++) begin
            @(posedge clk); #1;
            ack_now = comp && (k == w + 1);
            if (ack_now) begin
                if (oor) last_rd[t] = 8'h00;
                else if (rw) begin
                    mem_m[t][addr] = wd;
                    last_rd[t]     = 8'h00;
                end else last_rd[t] = mem_m[t][addr];
            end
            chk_all(k, t, ack_now, oor, (k < sel_cycles) || (comp && k == w + 2));
            // Bus noise after E0 must not disturb the latched request
            device_addr_in = 8'($urandom);
            rw_in          = 1'($urandom);
            wdata_in       = 8'($urandom);
            if (k + 1 < sel_cycles) begin
                hold_in = 1'b1;
            end else begin
                hold_in      = 1'b0;
                device_id_in = 5'($urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        hold_in = 1'b0;
        device_id_in = 5'd0;
        device_addr_in = 8'h00;
        rw_in = 1'b0;
        wdata_in = 8'h00;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        chk_all(-1, -1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Write then read back on WAIT=1 device
        txn(5'd1, 8'h10, 1'b1, 8'hA5, 3, 2);
        txn(5'd1, 8'h10, 1'b0, 8'h00, 3, 2);

        // Foreign ids, including the reserved no-device id
        txn(5'd2,  8'h10, 1'b1, 8'h11, 4, 2);
        txn(5'd31, 8'h10, 1'b1, 8'h22, 4, 2);
        txn(5'd1,  8'h10, 1'b0, 8'h00, 3, 2);

        // Abort in WAIT on WAIT=3 device
        txn(5'd4, 8'h20, 1'b1, 8'h3C, 2, 2);
        txn(5'd4, 8'h20, 1'b0, 8'h00, 5, 2);

        // Out of range on DEPTH=16, WAIT=0 device
        txn(5'd6, 8'h0F, 1'b1, 8'h77, 2, 2);
        txn(5'd6, 8'h10, 1'b1, 8'h99, 2, 2);
        txn(5'd6, 8'h0F, 1'b0, 8'h00, 2, 2);
        txn(5'd6, 8'h00, 1'b0, 8'h00, 2, 2);

        // Holdoff: sel kept 10 cycles past ack, one low cycle, then re-assert
        txn(5'd1, 8'h30, 1'b1, 8'h5A, 13, 1);
        txn(5'd1, 8'h30, 1'b0, 8'h00, 3, 2);

        // Reset during WAIT of a write
        hold_in        = 1'b1;
        device_id_in   = 5'd1;
        device_addr_in = 8'h05;
        rw_in          = 1'b1;
        wdata_in       = 8'hFF;
        @(posedge clk); #1;
        chk("busy_e0", 0, 0, {7'b0, busy_o[0]}, 8'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        model_clear();
        chk_all(1, -1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        hold_in = 1'b0;
        @(posedge clk); #1;
        txn(5'd1, 8'h05, 1'b0, 8'h00, 3, 2);
        txn(5'd1, 8'h10, 1'b0, 8'h00, 3, 2);

        // Randomized traffic, with occasional aborts and foreign ids
        for (int i = 0; i < 80; i++) begin
            logic [4:0] id;
            int         r;
            int         t;
            int         w;
            int         sc;
            r  = $urandom_range(0, 9);
            id = (r < 3) ? 5'd1 : (r < 6) ? 5'd4 : (r < 8) ? 5'd6 : (r == 8) ? 5'd31 : 5'd2;
            t  = dev_of(id);
            w  = (t >= 0) ? wait_of(t) : 2;
            if ($urandom_range(0, 3) == 0) sc = $urandom_range(1, w + 1);
            else                           sc = w + 2 + $urandom_range(0, 3);
            txn(id, 8'($urandom_range(0, 31)), 1'($urandom), 8'($urandom), sc, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
